// File: rtl/mux4_pkg.sv
// Shared constants and select-code type for the 4:1 lane selector.
// Imported by the core selector and the registered top.
package mux4_pkg;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_LANE0 = 2'd0,
    SEL_LANE1 = 2'd1,
    SEL_LANE2 = 2'd2,
    SEL_LANE3 = 2'd3
  } sel_e;

endpackage

// File: rtl/mux_4to1_core.sv
// Purely combinational WIDTH-bit 4:1 lane selector.
// Lane k lives at i[k*WIDTH +: WIDTH].
module mux_4to1_core
  import mux4_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [N_IN*WIDTH-1:0] i,
  input  logic [SEL_W-1:0]      j,
  output logic [WIDTH-1:0]      o
);

  sel_e sel;

  assign sel = sel_e'(j);

  // Unknown select leaves o at X in simulation; all codes are covered.
  always_comb begin
    o = 'x;
    unique case (sel)
      SEL_LANE0: o = i[0*WIDTH +: WIDTH];
      SEL_LANE1: o = i[1*WIDTH +: WIDTH];
      SEL_LANE2: o = i[2*WIDTH +: WIDTH];
      SEL_LANE3: o = i[3*WIDTH +: WIDTH];
    endcase
  end

endmodule

// File: rtl/mux_4to1.sv
// 4:1 lane selector with a combinational output and an
// enable-gated registered copy that resets asynchronously.
module mux_4to1
  import mux4_pkg::*;
#(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] i,
  input  logic [SEL_W-1:0]      j,
  input  logic                  en,
  output logic [WIDTH-1:0]      o,
  output logic [WIDTH-1:0]      o_q
);

  logic [WIDTH-1:0] o_q_d;
  logic [WIDTH-1:0] o_q_q;

  mux_4to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i (i),
    .j (j),
    .o (o)
  );

  always_comb begin
    o_q_d = o_q_q;
    if (en) o_q_d = o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_q_q <= RESET_VAL;
    else        o_q_q <= o_q_d;
  end

  assign o_q = o_q_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: 1-bit and 8-bit instances,
// combinational decode, enable gating and async reset.
module tb_mux_4to1;

  logic       clk;
  logic       rst_n;

  logic [3:0] i1;
  logic [1:0] j1;
  logic       en1;
  logic       o1;
  logic       oq1;

  logic [31:0] i8;
  logic [1:0]  j8;
  logic        en8;
  logic [7:0]  o8;
  logic [7:0]  oq8;

  int tests;
  int fails;

  mux_4to1 #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i1),
    .j     (j1),
    .en    (en1),
    .o     (o1),
    .o_q   (oq1)
  );

  mux_4to1 #(
    .WIDTH     (8),
    .RESET_VAL (8'h5A)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i8),
    .j     (j8),
    .en    (en8),
    .o     (o8),
    .o_q   (oq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] lanes [4];
    logic [3:0] iv;
    logic       ex;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en1   = 1'b0;
    en8   = 1'b0;
    i1    = 4'b0000;
    j1    = 2'd0;
    i8    = 32'hD4C3B2A1;
    j8    = 2'd0;

    #12;
    check("reset_oq1", {7'd0, oq1}, 8'h00);
    check("reset_oq8", oq8, 8'h5A);
    rst_n = 1'b1;

    // Selected lane set to 1: o must follow with no lag.
    i1 = 4'b0001; j1 = 2'd0; #1;
    check("sel0_hot", {7'd0, o1}, 8'h01);
    #99;
    i1 = 4'b0010; j1 = 2'd1; #1;
    check("sel1_hot", {7'd0, o1}, 8'h01);
    #99;
    i1 = 4'b0100; j1 = 2'd2; #1;
    check("sel2_hot", {7'd0, o1}, 8'h01);
    #99;
    i1 = 4'b1000; j1 = 2'd3; #1;
    check("sel3_hot", {7'd0, o1}, 8'h01);
    #99;

    i1 = 4'b0001; j1 = 2'd1; #1;
    check("mis_0001_j1", {7'd0, o1}, 8'h00);
    i1 = 4'b1110; j1 = 2'd0; #1;
    check("mis_1110_j0", {7'd0, o1}, 8'h00);
    i1 = 4'b1110; j1 = 2'd3; #1;
    check("mis_1110_j3", {7'd0, o1}, 8'h01);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        iv = 4'(a);
        ex = iv[b];
        i1 = iv;
        j1 = 2'(b);
        #1;
        check($sformatf("exh_i%0h_j%0d", a, b),
              {7'd0, o1}, {7'd0, ex});
      end
    end

    lanes[0] = 8'hA1;
    lanes[1] = 8'hB2;
    lanes[2] = 8'hC3;
    lanes[3] = 8'hD4;
    for (int b = 0; b < 4; b++) begin
      j8 = 2'(b);
      #1;
      check($sformatf("w8_j%0d", b), o8, lanes[b]);
    end

    // Registered path with enable.
    @(negedge clk);
    i1 = 4'b0100; j1 = 2'd2; en1 = 1'b1;
    j8 = 2'd2; en8 = 1'b1;
    @(posedge clk); #1;
    check("reg_load1", {7'd0, oq1}, 8'h01);
    check("reg_load8", oq8, 8'hC3);

    @(negedge clk);
    en1 = 1'b0; i1 = 4'b0000;
    en8 = 1'b0; j8 = 2'd0;
    @(posedge clk); #1;
    check("reg_hold1", {7'd0, oq1}, 8'h01);
    check("reg_hold8", oq8, 8'hC3);

    // Async reset between edges; o keeps tracking.
    @(negedge clk);
    i1 = 4'b1000; j1 = 2'd3; en1 = 1'b1;
    en8 = 1'b1; j8 = 2'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_oq1", {7'd0, oq1}, 8'h00);
    check("arst_oq8", oq8, 8'h5A);
    check("arst_o1", {7'd0, o1}, 8'h01);
    check("arst_o8", o8, 8'hD4);

    @(posedge clk); #1;
    check("arst_hold1", {7'd0, oq1}, 8'h00);
    check("arst_hold8", oq8, 8'h5A);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_noload1", {7'd0, oq1}, 8'h00);
    check("rel_noload8", oq8, 8'h5A);
    @(posedge clk); #1;
    check("rel_load1", {7'd0, oq1}, 8'h01);
    check("rel_load8", oq8, 8'hD4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
